// File: rtl/machchiaxung_pkg.sv
// Shared encodings and seed patterns for the N-output pulse distributor.
package machchiaxung_pkg;

  localparam int unsigned MAX_N = 32;

  localparam logic [1:0] MODE_RING    = 2'b00;
  localparam logic [1:0] MODE_WZERO   = 2'b01;
  localparam logic [1:0] MODE_JOHNSON = 2'b10;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Seed pattern of a mode for an n-bit output; reserved mode falls back to ring.
  function automatic logic [MAX_N-1:0] seed_of(input logic [1:0] mode, input int unsigned n);
    logic [MAX_N-1:0] mask;
    mask = (n >= MAX_N) ? '1 : ((MAX_N'(1) << n) - MAX_N'(1));
    case (mode)
      MODE_WZERO:   seed_of = mask & ~MAX_N'(1);
      MODE_JOHNSON: seed_of = '0;
      default:      seed_of = MAX_N'(1);
    endcase
  endfunction

endpackage

// File: rtl/xung_prescaler.sv
// Phase-length prescaler: fires step_c once every div+1 enabled cycles.
module xung_prescaler #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             step_c
);

  logic [DIV_W-1:0] pcnt;

  // >= so that lowering div mid-phase terminates the phase on the next cycle
  assign step_c = en && !clr && (pcnt >= div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= (pcnt >= div) ? '0 : pcnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/machchiaxung_n.sv
// N-output ring / walking-zero / Johnson pulse distributor with programmable phase length.
module machchiaxung_n
  import machchiaxung_pkg::*;
#(
  parameter int unsigned N_OUT = 4,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [DIV_W-1:0] div,
  output logic [N_OUT-1:0] q,
  output logic             tick,
  output logic             wrap
);

  logic [N_OUT-1:0] q_r;
  logic [N_OUT-1:0] q_step;
  logic [N_OUT-1:0] q_nxt;
  logic [N_OUT-1:0] seed_cur;
  logic [N_OUT-1:0] seed_new;
  logic [1:0]       mode_r;
  logic [1:0]       mode_in;
  logic             dir_r;
  logic             tick_r;
  logic             wrap_r;
  logic             step_c;
  logic             code_ok;

  assign q    = q_r;
  assign tick = tick_r;
  assign wrap = wrap_r;

  xung_prescaler #(.DIV_W(DIV_W)) u_pre (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .clr    (load),
    .div    (div),
    .step_c (step_c)
  );

  // Reserved encoding is stored as ring so the latched mode is always legal
  assign mode_in  = (mode == 2'b11) ? MODE_RING : mode;
  assign seed_cur = N_OUT'(seed_of(mode_r, N_OUT));
  assign seed_new = N_OUT'(seed_of(mode_in, N_OUT));

  // Next pattern; an illegal code for the latched mode is replaced by the seed
  always_comb begin
    code_ok = 1'b0;
    q_step  = q_r;
    case (mode_r)
      MODE_WZERO:   code_ok = ($countones(~q_r) == 1);
      MODE_JOHNSON: code_ok = ($countones(q_r[N_OUT-1:1] ^ q_r[N_OUT-2:0]) <= 1);
      default:      code_ok = ($countones(q_r) == 1);
    endcase
    if (mode_r == MODE_JOHNSON) begin
      q_step = (dir_r == DIR_DN) ? {~q_r[0], q_r[N_OUT-1:1]}
                                 : {q_r[N_OUT-2:0], ~q_r[N_OUT-1]};
    end else begin
      q_step = (dir_r == DIR_DN) ? {q_r[0], q_r[N_OUT-1:1]}
                                 : {q_r[N_OUT-2:0], q_r[N_OUT-1]};
    end
    q_nxt = code_ok ? q_step : seed_cur;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r    <= N_OUT'(seed_of(MODE_RING, N_OUT));
      mode_r <= MODE_RING;
      dir_r  <= DIR_UP;
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else if (load) begin
      q_r    <= seed_new;
      mode_r <= mode_in;
      dir_r  <= dir;
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else if (step_c) begin
      q_r    <= q_nxt;
      tick_r <= 1'b1;
      wrap_r <= (q_nxt == seed_cur);
    end else begin
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end
  end

endmodule

// File: doc/machchiaxung_n.md
Name: machchiaxung_n

Overview:
- Parametrised N-output pulse distributor (clock-pulse divider/sequencer), the successor of the 4-output ring distributor.
- A programmable prescaler sets how many clock cycles each output phase lasts.
- Output patterns: ring (walking-one), walking-zero or Johnson, each selectable up or down.
- Drives phase-sequenced enables (LED scan, multiplexed display digits, stepper phases) from one system clock.

Parameters:
N_OUT, 4, number of outputs q; legal range 2..32.
DIV_W, 8, width of the prescaler divide field.

Ports:
clk    in   1      system clock, rising edge
reset  in   1      asynchronous, active-high reset
en     in   1      advance enable; 0 freezes prescaler and q
load   in   1      synchronous reload: latch mode/dir, load seed pattern
mode   in   2      00 ring, 01 walking-zero, 10 Johnson, 11 reserved (treated as ring)
dir    in   1      0 up (towards MSB), 1 down (towards LSB)
div    in   DIV_W  each phase lasts div+1 clk cycles; sampled live
q      out  N_OUT  phase outputs, registered
tick   out  1      1-cycle pulse in the cycle q takes a new value from a step
wrap   out  1      1-cycle pulse, coincident with tick, when q returns to the seed

Behaviour:
- Reset (async, active-high):
  - q = seed of ring mode, i.e. bit0=1, all others 0.
  - Latched mode = ring, latched dir = up, pcnt = 0, tick = 0, wrap = 0.
  - Applies immediately, mid-phase included. First step occurs div+1 enabled cycles after reset deasserts.
- Seeds: ring = 0..01; walking-zero = 1..10; Johnson = all zeros.
- Priority per clock edge: load > en > hold.
- load=1:
  - Latches mode and dir.
  - q <= seed of the new mode; pcnt <= 0; tick = wrap = 0.
  - mode/dir changes without load are ignored.
- en=1, load=0:
  - If pcnt >= div: step, pcnt <= 0, tick <= 1. The >= compare means lowering div mid-phase takes effect next cycle, with no 2^DIV_W runaway.
  - Else pcnt <= pcnt+1, tick <= 0.
- en=0, load=0: pcnt and q hold; tick = wrap = 0.
- Step rules:
  - Ring / walking-zero, up: rotate left, q[N-1] to q[0].
  - Ring / walking-zero, down: rotate right.
  - Johnson up: q <= {q[N-2:0], ~q[N-1]}.
  - Johnson down: q <= {~q[0], q[N-1:1]}.
- Period: N_OUT steps for ring / walking-zero, 2*N_OUT steps for Johnson. Step period in cycles is (div+1).
- wrap <= 1 on a step whose next q equals the seed of the latched mode. Valid for both directions.
- Self-correction: in ring mode, if popcount(q) != 1 at a step, q <= seed instead (walking-zero: popcount(~q) != 1). In Johnson mode, a non-Johnson code at a step loads the seed. In every case wrap=1 on that step.
- div=0: q steps every enabled cycle; tick held high while en=1.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package machchiaxung_pkg:
  - mode encodings MODE_RING=2'b00, MODE_WZERO=2'b01, MODE_JOHNSON=2'b10.
  - DIR_UP=0, DIR_DN=1.
  - seed function seed_of(mode, N).
- Sub-module xung_prescaler (DIV_W): en, clr, div in; step pulse out; owns pcnt.
- Pattern register and next-state logic remain in the top module.

Test Plan:
1. N=4, mode=ring, dir=up, div=0, en=1 after reset -> q: 0001,0010,0100,1000,0001 on successive cycles; wrap high only on the 1000->0001 step.
2. div=2, ring up -> each q value held exactly 3 cycles; tick pulses every 3rd cycle. Change div 2->0 when pcnt=1 -> step on the next edge.
3. load with mode=Johnson, dir=up, div=0 -> q: 0000,0001,0011,0111,1111,1110,1100,1000,0000; wrap on the 8th step. Repeat with dir=down -> 0000,1000,1100,...
4. Ring, dir=down via load -> 0001,1000,0100,0010,0001. Walking-zero up -> 1110,1101,1011,0111,1110.
5. Assert reset asynchronously mid-phase (q=0100, pcnt=1) -> q=0001, tick=wrap=0 before the next clk edge. en=0 for 5 cycles -> q and pcnt frozen, tick=0. load and en both high -> load wins.
6. Force q=0110 in ring mode (via hierarchical deposit) -> next step gives q=0001 with wrap=1. Repeat with N_OUT=8, DIV_W=4 to check parametrisation.
